// File: rtl/mobius_inv_seq_if.sv
// Start/done handshake bundle for mobius_inv_seq.
// start is a request pulse taken only while the core is idle; done is a
// one-cycle pulse that marks outputs valid, and outputs then holds until
// the next accepted start. state_dbg mirrors the control FSM state.
interface mobius_inv_seq_if #(
   parameter int N = 512
);
   logic         start;
   logic [0:N-1] inputs;
   logic         busy;
   logic         done;
   logic [0:N-1] outputs;
   logic [1:0]   state_dbg;

   modport master (
      output start,
      output inputs,
      input  busy,
      input  done,
      input  outputs,
      input  state_dbg
   );

   modport slave (
      input  start,
      input  inputs,
      output busy,
      output done,
      output outputs,
      output state_dbg
   );
endinterface

// File: rtl/mobius_inv_seq.sv
// Iterative inverse Moebius transform over GF(2), one round per clock.
// Vectors are indexed [0:N-1] with element 0 leftmost. An inverse round
// de-interleaves the vector and then XORs the lower half into the upper half.
// Optional macro UNROLL2_EN chains two rounds per clock, with a single round
// in the final cycle when log2_N is odd.
module mobius_inv_seq #(
   parameter int N      = 512,
   parameter int log2_N = 9
) (
   input logic             clk,
   input logic             rst_n,
   mobius_inv_seq_if.slave bus
);
   localparam int CW = $clog2(log2_N + 1);
   localparam logic [CW-1:0] LAST = CW'(log2_N - 1);
`ifdef UNROLL2_EN
   localparam logic [CW-1:0] LAST_M1 = CW'(log2_N - 2);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] step;
   logic [0:N-1]  work;
   logic [0:N-1]  work_nxt;
   logic [0:N-1]  out_q;
   logic          last_cycle;
`ifdef UNROLL2_EN
   logic [0:N-1]  one_round;
   logic [0:N-1]  two_rounds;
`endif

   // De-interleave (even elements to the low half, odd to the high half),
   // then XOR each low-half element into its high-half partner.
   function automatic logic [0:N-1] inv_round(input logic [0:N-1] v);
      logic [0:N-1] m;
      logic [0:N-1] w;
      for (int i = 0; i < N / 2; i++) begin
         m[i]       = v[2 * i];
         m[i + N/2] = v[2 * i + 1];
      end
      for (int i = 0; i < N / 2; i++) begin
         w[i]       = m[i];
         w[i + N/2] = m[i + N/2] ^ m[i];
      end
      return w;
   endfunction

`ifdef UNROLL2_EN
   // Two rounds per cycle; an odd round count finishes with one round at cnt==LAST.
   always_comb begin
      one_round  = inv_round(work);
      two_rounds = inv_round(one_round);
      if (cnt == LAST) begin
         work_nxt = one_round;
         step     = CW'(1);
      end else begin
         work_nxt = two_rounds;
         step     = CW'(2);
      end
      last_cycle = (cnt >= LAST_M1);
   end
`else
   // One round per cycle; the round with cnt==LAST is the final one.
   always_comb begin
      work_nxt   = inv_round(work);
      step       = CW'(1);
      last_cycle = (cnt == LAST);
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_RUN;
         S_RUN:   if (last_cycle) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      bus.busy      = (state == S_RUN);
      bus.done      = (state == S_DONE);
      bus.state_dbg = state;
   end

   // Datapath: capture on accept, iterate during RUN, publish on the final round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work  <= '0;
         cnt   <= '0;
         out_q <= '0;
      end else begin
         if (state == S_IDLE && bus.start) begin
            work <= bus.inputs;
            cnt  <= '0;
         end else if (state == S_RUN) begin
            work <= work_nxt;
            cnt  <= cnt + step;
            if (last_cycle) out_q <= work_nxt;
         end
      end
   end

   assign bus.outputs = out_q;

endmodule

// File: tb/tb_mobius_inv_seq.sv
// Directed bench for mobius_inv_seq: an N=8 instance for hand-computed vectors,
// handshake corner cases and mid-run reset, and an N=512 instance checked
// against a forward Moebius reference on random vectors.
module tb_mobius_inv_seq;
   localparam int RUN8   = `ifdef UNROLL2_EN 2 `else 3 `endif;
   localparam int RUN512 = `ifdef UNROLL2_EN 5 `else 9 `endif;

   logic clk;
   logic rst8_n;
   logic rst512_n;
   int   errors;
   int   checks;
   logic [7:0]   prev8;
   logic [0:511] prev512;

   mobius_inv_seq_if #(.N(8))   if8 ();
   mobius_inv_seq_if #(.N(512)) if512 ();

   mobius_inv_seq #(.N(8), .log2_N(3)) dut8 (
      .clk   (clk),
      .rst_n (rst8_n),
      .bus   (if8.slave)
   );

   mobius_inv_seq #(.N(512), .log2_N(9)) dut512 (
      .clk   (clk),
      .rst_n (rst512_n),
      .bus   (if512.slave)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Forward Moebius transform, element index i, subset over index bits.
   function automatic logic [0:511] ref_mob(input logic [0:511] a);
      for (int s = 1; s < 512; s = s * 2)
         for (int i = 0; i < 512; i++)
            if ((i & s) != 0) a[i] = a[i] ^ a[i - s];
      return a;
   endfunction

   // One N=8 transform; hold_start keeps start high through RUN and DONE.
   task automatic run8(input string tag, input logic [7:0] vin,
                       input logic [7:0] exp, input bit hold_start);
      int n;
      if8.inputs = vin;
      if8.start  = 1'b1;
      tick();
      if (!hold_start) if8.start = 1'b0;
      if8.inputs = 8'($urandom);
      n = 0;
      while (if8.busy === 1'b1 && n < 20) begin
         check({tag, " out_stable"}, 512'(if8.outputs), 512'(prev8));
         tick();
         n++;
      end
      check({tag, " run_cycles"}, 512'(n), 512'(RUN8));
      check({tag, " done"}, 512'(if8.done), 512'(1));
      check({tag, " outputs"}, 512'(if8.outputs), 512'(exp));
      tick();
      if8.start = 1'b0;
      check({tag, " done_pulse"}, 512'(if8.done), 512'(0));
      tick();
      check({tag, " no_restart"}, 512'(if8.busy), 512'(0));
      check({tag, " held"}, 512'(if8.outputs), 512'(exp));
      prev8 = exp;
   endtask

   task automatic run512(input logic [0:511] vin);
      int n;
      logic [0:511] exp;
      exp = ref_mob(vin);
      if512.inputs = vin;
      if512.start  = 1'b1;
      tick();
      if512.start  = 1'b0;
      if512.inputs = '0;
      n = 0;
      while (if512.busy === 1'b1 && n < 30) begin
         if (if512.outputs !== prev512) check("n512 out_stable", if512.outputs, prev512);
         tick();
         n++;
      end
      check("n512 run_cycles", 512'(n), 512'(RUN512));
      check("n512 done", 512'(if512.done), 512'(1));
      check("n512 outputs", if512.outputs, exp);
      tick();
      check("n512 done_pulse", 512'(if512.done), 512'(0));
      prev512 = exp;
   endtask

   initial begin
      logic [0:511] v;
      errors = 0;
      checks = 0;
      prev8 = '0;
      prev512 = '0;
      if8.start = 1'b0;
      if8.inputs = '0;
      if512.start = 1'b0;
      if512.inputs = '0;
      rst8_n = 1'b0;
      rst512_n = 1'b0;
      #2;
      check("rst busy", 512'(if8.busy), 512'(0));
      check("rst done", 512'(if8.done), 512'(0));
      check("rst outputs", 512'(if8.outputs), 512'(0));
      check("rst state", 512'(if8.state_dbg), 512'(0));
      check("rst512 outputs", if512.outputs, '0);
      tick();
      tick();
      rst8_n = 1'b1;
      rst512_n = 1'b1;
      tick();

      // Hand-computed N=8 vectors, element 0 is the leftmost bit.
      run8("delta0", 8'b1000_0000, 8'b1111_1111, 1'b0);
      run8("ones", 8'hFF, 8'h80, 1'b0);
      run8("invol", 8'h80, 8'hFF, 1'b0);
      run8("delta1", 8'b0100_0000, 8'h55, 1'b0);
      run8("hold_start", 8'hFF, 8'h80, 1'b1);

      // Reset during the second RUN cycle takes effect without a clock edge.
      if8.inputs = 8'hFF;
      if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      tick();
      check("mid busy", 512'(if8.busy), 512'(1));
      #2;
      rst8_n = 1'b0;
      #1;
      check("abort busy", 512'(if8.busy), 512'(0));
      check("abort done", 512'(if8.done), 512'(0));
      check("abort outputs", 512'(if8.outputs), 512'(0));
      tick();
      check("abort no_done", 512'(if8.done), 512'(0));
      rst8_n = 1'b1;
      prev8 = '0;
      tick();
      run8("after_rst", 8'b1000_0000, 8'hFF, 1'b0);

      // Random N=512 vectors against the forward reference.
      for (int t = 0; t < 200; t++) begin
         for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
         run512(v);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mobius_inv_seq.md
Name: mobius_inv_seq

Overview:
- Iterative inverse Möbius transform over GF(2) on an N-bit vector, indexed [0:N-1] with bit 0 leftmost.
- Each cycle applies one inverse round, log2_N rounds per transform. An inverse round is an un-permute (de-interleave) followed by a butterfly.
- Sits downstream of the forward clocked Möbius core to recover ANF / truth-table vectors.
- Adds a start/done handshake and a round counter, which the forward core lacks.

Parameters:
- N, 512, vector width in bits; must be a power of two, N>=4.
- log2_N, 9, number of inverse rounds; must equal log2(N).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- inputs  input  N  vector to transform, [0:N-1]; captured on an accepted start.
- busy  output  1  high while rounds are executing.
- done  output  1  one-cycle pulse when outputs becomes valid.
- outputs  output  N  result, [0:N-1]; held until the next accepted start or reset.

Behaviour:
- Inverse round on v, producing w:
  - Un-permute: m[i]=v[2i] and m[i+N/2]=v[2i+1], for i in 0..N/2-1.
  - Butterfly: w[i]=m[i] and w[i+N/2]=m[i+N/2]^m[i].
  - Pure XOR, no carries.
- Because the GF(2) Möbius transform is an involution, the result equals the forward transform of the same input. The bench checks against this.
- Reset (asynchronous assert, synchronous deassert use): state=IDLE, round counter=0, working register=0, outputs=0, busy=0, done=0.
- States:
  - IDLE: busy=0. If start=1: working register <= inputs, counter <= 0, go to RUN.
  - RUN: busy=1. Each cycle: working register <= inv_round(working register), counter <= counter+1. When counter==log2_N-1, the final round is written to outputs and the state goes to DONE.
  - DONE: done=1 for exactly this cycle, busy=0; return to IDLE.
- Latency: start sampled on edge k; done=1 and outputs valid in the cycle after edge k+log2_N.
- start in RUN or DONE is ignored; no queuing. start in the same cycle done=1 is also ignored.
- outputs updates only on DONE entry; it is stable during RUN.
- Counter width is clog2(log2_N+1). There is no wrap; the counter resets to 0 on every accept.
- rst_n low mid-RUN aborts immediately: all outputs return to their reset values and no done pulse is produced.
- inputs may change freely after acceptance; only the captured copy is used.

Optional Feature:
- UNROLL2_EN defined:
  - Two inverse rounds are combinationally chained per cycle; counter steps by 2.
  - Latency is ceil(log2_N/2) RUN cycles. For odd log2_N, the last cycle applies a single round.
  - Result is identical to the undefined case.
- UNROLL2_EN undefined: one round per cycle, as above.

Test Plan:
- N=8, log2_N=3; inputs=8'b1000_0000, start pulse -> busy high 3 cycles, done pulse in the 4th cycle after start, outputs=8'b1111_1111.
- N=8; inputs=8'hFF -> outputs=8'h80. Feed 8'h80 again -> outputs=8'hFF (involution).
- N=512 default; 200 random vectors, each checked against a reference forward Möbius model. Each transform takes exactly 9 RUN cycles, followed by one done pulse.
- N=8; start re-asserted every cycle during RUN -> no restart, single done, outputs unchanged until the next accepted start.
- N=8; rst_n low on the 2nd RUN cycle -> busy=0, done=0, outputs=0 immediately with no clock needed. After release, a new start completes normally.
- UNROLL2_EN, N=8 (odd log2_N=3) -> done after 2 RUN cycles, outputs bit-identical to the non-unrolled run over 100 random vectors.
